charram_dram_ctrl: RTL and testbench

CHARRAM_DRAM_CTRL -- requirements
Module: charram_dram_ctrl

---
 rtl/charram_dram_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_charram_dram_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/charram_dram_ctrl.sv
// Character-RAM DRAM controller: arbitrates video, refresh and CPU accesses
// onto a multiplexed-address DRAM with one-cycle-per-state RAS/CAS sequencing.
`timescale 1ns/1ps
module charram_dram_ctrl #(
  parameter int REFRESH_INTERVAL = 128
) (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_VID_REQ,
  input  logic [13:0] i_VID_ADDR,
  output logic        o_VID_ACK,
  output logic [3:0]  o_VID_DATA,
  input  logic        i_CPU_REQ,
  input  logic        i_CPU_WR,
  input  logic [13:0] i_CPU_ADDR,
  input  logic [3:0]  i_CPU_DIN,
  output logic        o_CPU_ACK,
  output logic [3:0]  o_CPU_DATA,
  output logic [7:0]  o_DRAM_ADDR,
  output logic        o_DRAM_RAS_n,
  output logic        o_DRAM_CAS_n,
  output logic        o_DRAM_WR_n,
  output logic        o_DRAM_RD_n,
  output logic [3:0]  o_DRAM_DIN,
  input  logic [3:0]  i_DRAM_DOUT
);

  typedef enum logic [2:0] {IDLE, ROW, COL, ACC, PRE, REF} state_t;

  localparam logic [15:0] REF_LAST = 16'(REFRESH_INTERVAL - 1);

  state_t      state_reg, state_next;
  logic        recover_reg;
  logic [13:0] addr_reg, addr_next;
  logic        wr_reg, wr_next;
  logic [3:0]  din_reg, din_next;
  logic        owner_vid_reg, owner_vid_next;
  logic        access_reg, access_next;
  logic        grant_vid, grant_cpu, grant_ref;

  logic [15:0] ref_cnt_reg;
  logic        ref_pend_reg;
  logic [7:0]  ref_row_reg;

  logic        ras_n_reg, ras_n_next;
  logic        cas_n_reg, cas_n_next;
  logic        wr_n_reg, wr_n_next;
  logic        rd_n_reg, rd_n_next;
  logic [7:0]  dram_addr_reg, dram_addr_next;
  logic        vid_ack_reg, vid_ack_next;
  logic        cpu_ack_reg, cpu_ack_next;
  logic [3:0]  vid_data_reg, cpu_data_reg;
  logic        finish;

  always_comb begin
    state_next     = state_reg;
    grant_vid      = 1'b0;
    grant_cpu      = 1'b0;
    grant_ref      = 1'b0;
    addr_next      = addr_reg;
    wr_next        = wr_reg;
    din_next       = din_reg;
    owner_vid_next = owner_vid_reg;
    access_next    = access_reg;

    // recover_reg marks the IDLE right after PRE: nobody is granted there,
    // which both guarantees RAS precharge and keeps an acked requester out.
    case (state_reg)
      IDLE: begin
        if (!recover_reg) begin
          if (i_VID_REQ)         grant_vid = 1'b1;
          else if (ref_pend_reg) grant_ref = 1'b1;
          else if (i_CPU_REQ)    grant_cpu = 1'b1;
        end
        if (grant_vid || grant_cpu) state_next = ROW;
        else if (grant_ref)         state_next = REF;
      end
      ROW:     state_next = COL;
      COL:     state_next = ACC;
      ACC:     state_next = PRE;
      PRE:     state_next = IDLE;
      REF:     state_next = PRE;
      default: state_next = IDLE;
    endcase

    if (grant_vid) begin
      addr_next      = i_VID_ADDR;
      wr_next        = 1'b0;
      owner_vid_next = 1'b1;
      access_next    = 1'b1;
    end
    if (grant_cpu) begin
      addr_next      = i_CPU_ADDR;
      wr_next        = i_CPU_WR;
      din_next       = i_CPU_DIN;
      owner_vid_next = 1'b0;
      access_next    = 1'b1;
    end
    if (grant_ref) access_next = 1'b0;

    // Strobes are decoded from the next state so the registers line up with it.
    ras_n_next     = 1'b1;
    cas_n_next     = 1'b1;
    wr_n_next      = 1'b1;
    rd_n_next      = 1'b1;
    dram_addr_next = dram_addr_reg;
    case (state_next)
      ROW: begin
        ras_n_next     = 1'b0;
        dram_addr_next = addr_next[7:0];
      end
      REF: begin
        ras_n_next     = 1'b0;
        dram_addr_next = ref_row_reg;
      end
      COL: begin
        ras_n_next     = 1'b0;
        cas_n_next     = 1'b0;
        dram_addr_next = {1'b0, addr_next[13:8], 1'b0};
      end
      ACC: begin
        ras_n_next     = 1'b0;
        cas_n_next     = 1'b0;
        wr_n_next      = ~wr_next;
        rd_n_next      = wr_next;
        dram_addr_next = {1'b0, addr_next[13:8], 1'b0};
      end
      default: ;
    endcase

    finish       = (state_reg == PRE) && access_reg;
    vid_ack_next = finish && owner_vid_reg;
    cpu_ack_next = finish && !owner_vid_reg;
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_reg     <= IDLE;
      recover_reg   <= 1'b0;
      addr_reg      <= '0;
      wr_reg        <= 1'b0;
      din_reg       <= '0;
      owner_vid_reg <= 1'b0;
      access_reg    <= 1'b0;
      ref_cnt_reg   <= '0;
      ref_pend_reg  <= 1'b0;
      ref_row_reg   <= '0;
      ras_n_reg     <= 1'b1;
      cas_n_reg     <= 1'b1;
      wr_n_reg      <= 1'b1;
      rd_n_reg      <= 1'b1;
      dram_addr_reg <= '0;
      vid_ack_reg   <= 1'b0;
      cpu_ack_reg   <= 1'b0;
      vid_data_reg  <= '0;
      cpu_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      recover_reg   <= (state_reg == PRE);
      addr_reg      <= addr_next;
      wr_reg        <= wr_next;
      din_reg       <= din_next;
      owner_vid_reg <= owner_vid_next;
      access_reg    <= access_next;
      ras_n_reg     <= ras_n_next;
      cas_n_reg     <= cas_n_next;
      wr_n_reg      <= wr_n_next;
      rd_n_reg      <= rd_n_next;
      dram_addr_reg <= dram_addr_next;
      vid_ack_reg   <= vid_ack_next;
      cpu_ack_reg   <= cpu_ack_next;

      if (ref_cnt_reg == REF_LAST) ref_cnt_reg <= '0;
      else                         ref_cnt_reg <= ref_cnt_reg + 16'd1;

      // A fresh expiry wins over the clear; repeated expiries just keep it set.
      if (ref_cnt_reg == REF_LAST) ref_pend_reg <= 1'b1;
      else if (grant_ref)          ref_pend_reg <= 1'b0;

      if (state_reg == REF) ref_row_reg <= ref_row_reg + 8'd1;

      if (finish && !wr_reg) begin
        if (owner_vid_reg) vid_data_reg <= i_DRAM_DOUT;
        else               cpu_data_reg <= i_DRAM_DOUT;
      end
    end
  end

  assign o_VID_ACK    = vid_ack_reg;
  assign o_VID_DATA   = vid_data_reg;
  assign o_CPU_ACK    = cpu_ack_reg;
  assign o_CPU_DATA   = cpu_data_reg;
  assign o_DRAM_ADDR  = dram_addr_reg;
  assign o_DRAM_RAS_n = ras_n_reg;
  assign o_DRAM_CAS_n = cas_n_reg;
  assign o_DRAM_WR_n  = wr_n_reg;
  assign o_DRAM_RD_n  = rd_n_reg;
  assign o_DRAM_DIN   = din_reg;

endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Directed bench for charram_dram_ctrl with a small behavioural DRAM attached.
`timescale 1ns/1ps
module tb_charram_dram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vid_req = 1'b0;
  logic [13:0] vid_addr = '0;
  logic        vid_ack;
  logic [3:0]  vid_data;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [3:0]  cpu_din = '0;
  logic        cpu_ack;
  logic [3:0]  cpu_data;
  logic [7:0]  dram_addr;
  logic        ras_n, cas_n, wr_n, rd_n;
  logic [3:0]  dram_din;
  logic [3:0]  dram_dout = '0;

  logic [3:0]  strb;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  charram_dram_ctrl #(.REFRESH_INTERVAL(16)) dut (
    .i_MCLK(clk), .i_RST(rst),
    .i_VID_REQ(vid_req), .i_VID_ADDR(vid_addr), .o_VID_ACK(vid_ack), .o_VID_DATA(vid_data),
    .i_CPU_REQ(cpu_req), .i_CPU_WR(cpu_wr), .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
    .o_CPU_ACK(cpu_ack), .o_CPU_DATA(cpu_data),
    .o_DRAM_ADDR(dram_addr), .o_DRAM_RAS_n(ras_n), .o_DRAM_CAS_n(cas_n),
    .o_DRAM_WR_n(wr_n), .o_DRAM_RD_n(rd_n), .o_DRAM_DIN(dram_din), .i_DRAM_DOUT(dram_dout)
  );

  always #5 clk = ~clk;
  assign strb = {ras_n, cas_n, wr_n, rd_n};

  // DRAM model: row latched on RAS-only cycles, column taken from the address bus.
  logic [3:0] mem [16384];
  logic [7:0] row_l = '0;
  always @(posedge clk) begin
    if (!ras_n && cas_n) row_l <= dram_addr;
    if (!wr_n) mem[{dram_addr[6:1], row_l}] <= dram_din;
    if (!rd_n) dram_dout <= mem[{dram_addr[6:1], row_l}];
  end

  task automatic step;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; vid_req = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if (strb !== 4'hF) begin n_bad++; $display("FAIL reset_strobes: got %b expected 1111", strb); end
    n_cmp++; if (dram_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr: got %h expected 00", dram_addr); end
    n_cmp++; if (dram_din !== 4'h0) begin n_bad++; $display("FAIL reset_din: got %h expected 0", dram_din); end
    n_cmp++; if ({vid_data, cpu_data} !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", {vid_data, cpu_data}); end
    n_cmp++; if ({vid_ack, cpu_ack} !== 2'b00) begin n_bad++; $display("FAIL reset_acks: got %b expected 00", {vid_ack, cpu_ack}); end
    step;
    n_cmp++; if (strb !== 4'hF) begin n_bad++; $display("FAIL idle_strobes: got %b expected 1111", strb); end
  endtask

  task automatic test_cpu_access(input bit is_wr);
    bit [3:0] exp_strb [6];
    bit [7:0] exp_addr [6] = '{8'h5C, 8'h54, 8'h54, 8'h54, 8'h54, 8'h54};
    exp_strb = '{4'b0111, 4'b0011, (is_wr ? 4'b0001 : 4'b0010), 4'b1111, 4'b1111, 4'b1111};
    do_reset;
    cpu_req = 1'b1; cpu_wr = is_wr; cpu_addr = 14'h2A5C; cpu_din = is_wr ? 4'hB : 4'h3;
    for (int k = 1; k <= 6; k++) begin
      step;
      n_cmp++; if (strb !== exp_strb[k-1]) begin n_bad++; $display("FAIL cpu_strobes wr=%0d cyc=%0d: got %b expected %b", is_wr, k, strb, exp_strb[k-1]); end
      n_cmp++; if (dram_addr !== exp_addr[k-1]) begin n_bad++; $display("FAIL cpu_addr wr=%0d cyc=%0d: got %h expected %h", is_wr, k, dram_addr, exp_addr[k-1]); end
      n_cmp++; if (cpu_ack !== (k == 5)) begin n_bad++; $display("FAIL cpu_ack wr=%0d cyc=%0d: got %b expected %b", is_wr, k, cpu_ack, (k == 5)); end
      if (is_wr && k == 3) begin
        n_cmp++; if (dram_din !== 4'hB) begin n_bad++; $display("FAIL cpu_din: got %h expected b", dram_din); end
      end
      if (k == 5) begin
        n_cmp++; if (cpu_data !== (is_wr ? 4'h0 : 4'hB)) begin n_bad++; $display("FAIL cpu_data wr=%0d: got %h expected %h", is_wr, cpu_data, (is_wr ? 4'h0 : 4'hB)); end
      end
      if (cpu_ack) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    $display("cpu %s 0x2A5C done, data=%h", is_wr ? "write" : "read", cpu_data);
  endtask

  task automatic test_vid_cpu;
    int vid_ack_cyc = -1, cpu_ack_cyc = -1, nf = 0, viol = 0;
    int falls [4] = '{-1, -1, -1, -1};
    logic prev_ras = 1'b1;
    do_reset;
    vid_req = 1'b1; vid_addr = 14'h2A5C;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h0101; cpu_din = 4'h6;
    for (int k = 1; k <= 14; k++) begin
      step;
      if (!ras_n && prev_ras) begin if (nf < 4) falls[nf] = k; nf++; end
      prev_ras = ras_n;
      if ((!rd_n && !wr_n) || (!cas_n && ras_n)) viol++;
      if (vid_ack && vid_ack_cyc < 0) vid_ack_cyc = k;
      if (cpu_ack && cpu_ack_cyc < 0) cpu_ack_cyc = k;
      if (vid_ack) begin
        n_cmp++; if (vid_data !== 4'hB) begin n_bad++; $display("FAIL vid_data: got %h expected b", vid_data); end
        vid_req = 1'b0;
      end
      if (cpu_ack) cpu_req = 1'b0;
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    n_cmp++; if (vid_ack_cyc !== 5) begin n_bad++; $display("FAIL vc_vid_ack_cycle: got %0d expected 5", vid_ack_cyc); end
    n_cmp++; if (falls[1] !== 7) begin n_bad++; $display("FAIL vc_cpu_row_cycle: got %0d expected 7", falls[1]); end
    n_cmp++; if (cpu_ack_cyc !== 11) begin n_bad++; $display("FAIL vc_cpu_ack_cycle: got %0d expected 11", cpu_ack_cyc); end
    n_cmp++; if (nf !== 2) begin n_bad++; $display("FAIL vc_ras_falls: got %0d expected 2", nf); end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL vc_strobe_overlap: got %0d expected 0", viol); end
    $display("video+cpu: vid ack @%0d, cpu ack @%0d", vid_ack_cyc, cpu_ack_cyc);
  endtask

  task automatic test_refresh;
    int nref = 0, bad = 0, first = -1;
    logic [7:0] rows [8];
    do_reset;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) step;
      if (!ras_n) begin
        if (first < 0) first = k;
        if (nref < 8) rows[nref] = dram_addr;
        nref++;
      end
      if (!cas_n || !wr_n || !rd_n) bad++;
    end
    n_cmp++; if (nref !== 6) begin n_bad++; $display("FAIL ref_count: got %0d expected 6", nref); end
    n_cmp++; if (first !== 17) begin n_bad++; $display("FAIL ref_first_cycle: got %0d expected 17", first); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL ref_strobes: got %0d bad cycles expected 0", bad); end
    for (int i = 0; i < 6 && i < nref; i++) begin
      n_cmp++; if (rows[i] !== 8'(i)) begin n_bad++; $display("FAIL ref_row%0d: got %h expected %h", i, rows[i], 8'(i)); end
    end
    $display("refresh: %0d REF cycles, first @%0d", nref, first);
  endtask

  // Requests are raised in cycle 16, the first cycle refresh is pending.
  task automatic test_refresh_prio(input bit with_vid);
    int nf = 0, vid_ack_cyc = -1, cpu_ack_cyc = -1;
    int fc [4] = '{-1, -1, -1, -1};
    logic [7:0] fa [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    int exp_fc [3];
    logic [7:0] exp_fa [3];
    int exp_nf, exp_cpu_ack;
    logic prev_ras = 1'b1;
    if (with_vid) begin
      exp_fc = '{17, 23, 27}; exp_fa = '{8'h5C, 8'h00, 8'h77}; exp_nf = 3; exp_cpu_ack = 31;
    end else begin
      exp_fc = '{17, 21, -1}; exp_fa = '{8'h00, 8'h77, 8'hFF}; exp_nf = 2; exp_cpu_ack = 25;
    end
    do_reset;
    while (cyc < 16) step;
    cpu_req = 1'b1; cpu_wr = !with_vid; cpu_addr = 14'h0377; cpu_din = 4'h9;
    vid_req = with_vid; vid_addr = 14'h2A5C;
    for (int k = 17; k <= 32; k++) begin
      step;
      if (!ras_n && prev_ras) begin if (nf < 4) begin fc[nf] = k; fa[nf] = dram_addr; end nf++; end
      prev_ras = ras_n;
      if (vid_ack && vid_ack_cyc < 0) begin vid_ack_cyc = k; vid_req = 1'b0; end
      if (cpu_ack && cpu_ack_cyc < 0) begin
        cpu_ack_cyc = k; cpu_req = 1'b0;
        if (with_vid) begin
          n_cmp++; if (cpu_data !== 4'h9) begin n_bad++; $display("FAIL rp_cpu_data: got %h expected 9", cpu_data); end
        end
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    n_cmp++; if (nf !== exp_nf) begin n_bad++; $display("FAIL rp_falls vid=%0d: got %0d expected %0d", with_vid, nf, exp_nf); end
    for (int i = 0; i < exp_nf; i++) begin
      n_cmp++; if (fc[i] !== exp_fc[i] || fa[i] !== exp_fa[i]) begin
        n_bad++; $display("FAIL rp_ras%0d vid=%0d: got cyc %0d addr %h expected cyc %0d addr %h", i, with_vid, fc[i], fa[i], exp_fc[i], exp_fa[i]);
      end
    end
    n_cmp++; if (cpu_ack_cyc !== exp_cpu_ack) begin n_bad++; $display("FAIL rp_cpu_ack vid=%0d: got %0d expected %0d", with_vid, cpu_ack_cyc, exp_cpu_ack); end
    if (with_vid) begin
      n_cmp++; if (vid_ack_cyc !== 21 || vid_data !== 4'hB) begin n_bad++; $display("FAIL rp_vid_ack: got cyc %0d data %h expected cyc 21 data b", vid_ack_cyc, vid_data); end
    end
    $display("refresh priority vid=%0d: cpu ack @%0d", with_vid, cpu_ack_cyc);
  endtask

  task automatic test_reset_mid;
    int cpu_ack_cyc = -1;
    do_reset;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 14'h0101; cpu_din = 4'h5;
    step; step;
    n_cmp++; if (strb !== 4'b0011) begin n_bad++; $display("FAIL rm_in_col: got %b expected 0011", strb); end
    rst = 1'b1;
    step;
    n_cmp++; if (strb !== 4'hF) begin n_bad++; $display("FAIL rm_strobes: got %b expected 1111", strb); end
    n_cmp++; if ({vid_ack, cpu_ack} !== 2'b00) begin n_bad++; $display("FAIL rm_acks: got %b expected 00", {vid_ack, cpu_ack}); end
    n_cmp++; if ({dram_addr, dram_din, vid_data} !== 16'h0000) begin n_bad++; $display("FAIL rm_regs: got %h expected 0000", {dram_addr, dram_din, vid_data}); end
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 7; k++) begin
      step;
      if (cpu_ack && cpu_ack_cyc < 0) begin cpu_ack_cyc = k; cpu_req = 1'b0; end
    end
    cpu_req = 1'b0;
    n_cmp++; if (cpu_ack_cyc !== 5) begin n_bad++; $display("FAIL rm_retry_ack: got %0d expected 5", cpu_ack_cyc); end
    n_cmp++; if (mem[14'h0101] !== 4'h5) begin n_bad++; $display("FAIL rm_retry_write: got %h expected 5", mem[14'h0101]); end
    $display("reset during COL: retry ack @%0d", cpu_ack_cyc);
  endtask

  initial begin
    test_reset;
    test_cpu_access(1'b1);
    test_cpu_access(1'b0);
    test_vid_cpu;
    test_refresh;
    test_refresh_prio(1'b0);
    test_refresh_prio(1'b1);
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
